// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage with single-outstanding imem requests and the IF/ID register
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0100,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_src,
  input  logic [31:0] pfc,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        id_flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic [6:0]  if_id_opcode
);
  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} state_t;
  state_t state, state_nxt;
  logic [31:0] fetch_pc, pc_nxt, pc_inc, target, hold_q;
  logic redirect, take, capture, load;
  assign imem_req = rst & (state == ISSUE);
  assign imem_addr = fetch_pc;
  assign if_id_opcode = if_id_inst[6:0];
  always_comb begin
    redirect = pc_write & (pc_src == 2'b01 | pc_src == 2'b10);
    target = {(pc_src == 2'b10 ? EXC_VECTOR[31:2] : pfc[31:2]), 2'b00};
    pc_inc = fetch_pc + 32'd4;
    take = !redirect & ((state == WAIT & imem_valid) | state == HOLD);
    capture = take & (state == WAIT) & !id_flush & !if_id_write;
    load = take & !id_flush & if_id_write;
    state_nxt = state;
    pc_nxt = fetch_pc;
    case (state)
      ISSUE: begin
        state_nxt = redirect ? DROP : WAIT;
        pc_nxt = redirect ? target : fetch_pc;
      end
      WAIT: begin
        if (redirect) begin
          pc_nxt = target;
          state_nxt = imem_valid ? ISSUE : DROP;
        end else if (imem_valid) begin
          state_nxt = capture ? HOLD : ISSUE;
          pc_nxt = capture ? fetch_pc : pc_inc;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nxt = target;
          state_nxt = ISSUE;
        end else if (id_flush | if_id_write) begin
          pc_nxt = pc_inc;
          state_nxt = ISSUE;
        end
      end
      default: begin
        pc_nxt = redirect ? target : fetch_pc;
        state_nxt = imem_valid ? ISSUE : DROP;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ISSUE;
      fetch_pc <= RESET_PC;
      hold_q <= '0;
      if_id_pc <= '0;
      if_id_inst <= NOP_INST;
      if_id_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      fetch_pc <= pc_nxt;
      if (capture) hold_q <= imem_rdata;
      if (load) if_id_pc <= fetch_pc;
      if (id_flush | if_id_write) begin
        if_id_valid <= load;
        if_id_inst <= load ? (state == HOLD ? hold_q : imem_rdata) : NOP_INST;
      end
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized and directed checks of if_stage against a transaction-level fetch model
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] K = 32'hA5A5_0000;
  localparam logic [104:0] RST_VEC = {1'b0, 32'h0, 32'h0, NOP, 1'b0, 7'h13};
  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] pc_src;
  logic [31:0] pfc, imem_rdata, imem_addr, if_id_pc, if_id_inst;
  logic pc_write, if_id_write, id_flush, imem_valid, imem_req, if_id_valid;
  logic [6:0] if_id_opcode;
  int vectors = 0, misc = 0;
  int cnt = 0, lat = 1;
  logic [31:0] aq, r_addr;
  logic r_req;
  logic m_issue, m_stale, m_held, m_ival;
  logic [31:0] m_pc, m_word, m_ipc, m_inst;
  always #5 clk = ~clk;
  if_stage dut (
    .clk(clk), .rst(rst), .pc_src(pc_src), .pfc(pfc), .pc_write(pc_write),
    .if_id_write(if_id_write), .id_flush(id_flush), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .if_id_pc(if_id_pc), .if_id_inst(if_id_inst), .if_id_valid(if_id_valid),
    .if_id_opcode(if_id_opcode)
  );
  wire [104:0] obs = {imem_req, imem_addr, if_id_pc, if_id_inst, if_id_valid, if_id_opcode};
  wire [104:0] expv = {rst & m_issue, m_pc, m_ipc, m_inst, m_ival, m_inst[6:0]};
  task automatic neutral;
    pc_src = 2'b00; pfc = 32'h0; pc_write = 1'b1; if_id_write = 1'b1; id_flush = 1'b0;
  endtask
  task automatic model_reset;
    m_issue = 1'b1; m_stale = 1'b0; m_held = 1'b0; m_pc = 32'h0;
    m_word = 32'h0; m_ipc = 32'h0; m_inst = NOP; m_ival = 1'b0;
  endtask
  // One clock of fetch behaviour: issue a fetch, await it, park it, or throw away a stale one.
  task automatic model_step;
    logic redir, dlv;
    logic [31:0] tgt, w;
    redir = pc_write && (pc_src == 2'b01 || pc_src == 2'b10);
    tgt = (pc_src == 2'b10 ? 32'h100 : pfc) & 32'hFFFF_FFFC;
    dlv = !m_issue && !m_stale && (m_held || imem_valid) && !redir;
    w = m_held ? m_word : imem_rdata;
    if (id_flush) begin
      m_ival = 1'b0; m_inst = NOP;
    end else if (if_id_write) begin
      m_ival = dlv; m_inst = dlv ? w : NOP;
      if (dlv) m_ipc = m_pc;
    end
    if (m_issue) begin
      m_issue = 1'b0; m_stale = redir;
      if (redir) m_pc = tgt;
    end else if (m_stale) begin
      if (redir) m_pc = tgt;
      if (imem_valid) begin m_issue = 1'b1; m_stale = 1'b0; end
    end else if (m_held) begin
      if (redir) m_pc = tgt; else if (id_flush || if_id_write) m_pc = m_pc + 4;
      m_issue = redir || id_flush || if_id_write;
      m_held = !m_issue;
    end else if (imem_valid) begin
      if (redir) m_pc = tgt;
      else if (id_flush || if_id_write) m_pc = m_pc + 4;
      else begin m_held = 1'b1; m_word = imem_rdata; end
      m_issue = !m_held;
    end else if (redir) begin
      m_pc = tgt; m_stale = 1'b1;
    end
  endtask
  task automatic mem_step;
    if (cnt > 0) cnt--;
    if (r_req) begin cnt = lat; aq = r_addr; end
    imem_valid = (cnt == 1);
    imem_rdata = imem_valid ? aq ^ K : $urandom;
  endtask
  task automatic tick;
    r_req = imem_req; r_addr = imem_addr;
    @(posedge clk); #1;
    if (!rst) model_reset(); else model_step();
    mem_step();
  endtask
  task automatic test_reset;
    #2;
    vectors++;
    if (obs !== RST_VEC) begin misc++; $display("FAIL reset got=%h want=%h", obs, RST_VEC); end
    tick();
    rst = 1'b1;
  endtask
  task automatic test_seq;
    logic [31:0] seen[$];
    lat = 1;
    repeat (8) begin
      #2;
      vectors++;
      if (obs !== expv) begin misc++; $display("FAIL seq got=%h want=%h", obs, expv); end
      if (if_id_valid) seen.push_back(if_id_pc);
      tick();
    end
    vectors++;
    if (seen.size() != 3 || seen[0] != 0 || seen[1] != 4 || seen[2] != 8) begin
      misc++; $display("FAIL seq_order got_count=%0d want=3 (pcs 0,4,8)", seen.size());
    end
  endtask
  task automatic test_stall;
    for (int i = 0; i < 12; i++) begin
      if_id_write = !(i >= 1 && i <= 3);
      #2;
      vectors++;
      if (obs !== expv) begin misc++; $display("FAIL stall got=%h want=%h", obs, expv); end
      tick();
    end
  endtask
  task automatic test_redirect;
    logic hit = 1'b0;
    int i = 0;
    lat = 3;
    while (i < 10 && !(!m_issue && !m_stale && !m_held)) begin tick(); i++; end
    for (int j = 0; j < 14; j++) begin
      neutral();
      if (j == 0) begin pc_src = 2'b01; pfc = 32'h40; end
      #2;
      vectors++;
      if (obs !== expv) begin misc++; $display("FAIL redirect got=%h want=%h", obs, expv); end
      if (imem_req && imem_addr == 32'h40) hit = 1'b1;
      tick();
    end
    vectors++;
    if (hit !== 1'b1) begin misc++; $display("FAIL redirect_req got=%b want=1", hit); end
  endtask
  task automatic test_exc;
    logic early = 1'b0, hit = 1'b0;
    lat = 1;
    for (int j = 0; j < 16; j++) begin
      neutral();
      if (j < 4) begin pc_src = 2'b10; pc_write = 1'b0; end
      if (j == 6) pc_src = 2'b10;
      #2;
      vectors++;
      if (obs !== expv) begin misc++; $display("FAIL exc got=%h want=%h", obs, expv); end
      if (imem_req && imem_addr == 32'h100) begin if (j <= 6) early = 1'b1; else hit = 1'b1; end
      tick();
    end
    vectors++;
    if ({early, hit} !== 2'b01) begin misc++; $display("FAIL exc_req got=%b want=01", {early, hit}); end
  endtask
  task automatic test_flush;
    int i = 0;
    neutral();
    lat = 1;
    while (i < 10 && !(!m_issue && !m_stale && !m_held && imem_valid)) begin tick(); i++; end
    for (int j = 0; j < 6; j++) begin
      id_flush = (j == 0);
      #2;
      vectors++;
      if (obs !== expv) begin misc++; $display("FAIL flush got=%h want=%h", obs, expv); end
      tick();
    end
  endtask
  task automatic test_wrap;
    logic top = 1'b0, wrapped = 1'b0;
    int i = 0;
    neutral();
    while (i < 10 && !m_issue) begin tick(); i++; end
    for (int j = 0; j < 10; j++) begin
      neutral();
      if (j == 0) begin pc_src = 2'b01; pfc = 32'hFFFF_FFFF; end
      #2;
      vectors++;
      if (obs !== expv) begin misc++; $display("FAIL wrap got=%h want=%h", obs, expv); end
      if (imem_req && imem_addr == 32'hFFFF_FFFC) top = 1'b1;
      if (top && imem_req && imem_addr == 32'h0) wrapped = 1'b1;
      tick();
    end
    vectors++;
    if (wrapped !== 1'b1) begin misc++; $display("FAIL wrap_req got=%b want=1", wrapped); end
  endtask
  task automatic test_reset_mid;
    int i = 0;
    neutral();
    lat = 3;
    while (i < 10 && !(!m_issue && !m_stale && !m_held)) begin tick(); i++; end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (obs !== RST_VEC) begin misc++; $display("FAIL reset_mid got=%h want=%h", obs, RST_VEC); end
    model_reset();
    cnt = 0;
    tick();
    rst = 1'b1;
    cnt = 1;
    imem_valid = 1'b1;
    imem_rdata = $urandom;
    for (int j = 0; j < 10; j++) begin
      #2;
      vectors++;
      if (obs !== expv) begin misc++; $display("FAIL reset_release got=%h want=%h", obs, expv); end
      tick();
    end
  endtask
  task automatic test_random;
    for (int j = 0; j < 600; j++) begin
      pc_src = 2'($urandom_range(0, 3));
      pfc = $urandom;
      pc_write = ($urandom_range(0, 9) < 7);
      if_id_write = ($urandom_range(0, 3) != 0);
      id_flush = ($urandom_range(0, 9) == 0);
      lat = $urandom_range(1, 3);
      #2;
      vectors++;
      if (obs !== expv) begin misc++; $display("FAIL random got=%h want=%h", obs, expv); end
      tick();
    end
  endtask
  initial begin
    neutral();
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_seq();
    test_stall();
    test_redirect();
    test_exc();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage directly upstream of the decode stage. It owns the fetch PC and issues single-outstanding requests to instruction memory. It also owns the IF/ID pipeline register that feeds pc/inst into decode, and it applies the redirect (pc_src/pfc), stall (pc_write/if_id_write) and flush (id_flush) controls that decode produces.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
EXC_VECTOR, 32'h0000_0100, redirect target when pc_src = 2'b10
NOP_INST, 32'h0000_0013, instruction placed in IF/ID on a bubble

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
pc_src  in  2  from decode: 00 sequential, 01 branch/jump to pfc, 10 exception, 11 treated as 00
pfc  in  32  branch/jump target from decode
pc_write  in  1  0 = decode stall; redirects are ignored while 0
if_id_write  in  1  0 = hold IF/ID register contents
id_flush  in  1  1 = load bubble into IF/ID
imem_req  out  1  one-cycle request pulse
imem_addr  out  32  request address (= fetch_pc)
imem_rdata  in  32  fetched word
imem_valid  in  1  imem_rdata valid; one pulse per request, latency >= 1 cycle
if_id_pc  out  32  PC of instruction in IF/ID
if_id_inst  out  32  instruction in IF/ID
if_id_valid  out  1  1 = real instruction, 0 = bubble
if_id_opcode  out  7  if_id_inst[6:0], combinational

Behaviour:
- Reset (rst = 0, asynchronous):
  - fetch_pc = RESET_PC; state = ISSUE.
  - if_id_pc = 0, if_id_inst = NOP_INST, if_id_valid = 0; hold register cleared.
  - imem_req is forced to 0 while rst = 0.
  - Reset mid-request abandons the request; any imem_valid in the first cycle after release is ignored, because the state is ISSUE, not WAIT.
- redirect = pc_write & (pc_src == 01 or pc_src == 10).
  - target = pfc for 01, EXC_VECTOR for 10; target[1:0] forced to 00.
- imem_req = (state == ISSUE); imem_addr = fetch_pc at all times. At most one request is outstanding.
- FSM states: ISSUE, WAIT, HOLD, DROP.
  - ISSUE: pulse the request, go to WAIT. If redirect this cycle: fetch_pc <= target, go to DROP (the issued request is stale).
  - WAIT, imem_valid & redirect: discard the data, fetch_pc <= target, go to ISSUE.
  - WAIT, imem_valid & if_id_write & !id_flush: load IF/ID (pc = fetch_pc, inst = imem_rdata, valid = 1), fetch_pc <= fetch_pc + 4, go to ISSUE.
  - WAIT, imem_valid & !if_id_write & !id_flush: capture the word in the hold register, go to HOLD.
  - WAIT, imem_valid & id_flush (no redirect): discard, fetch_pc <= fetch_pc + 4, go to ISSUE.
  - WAIT, no imem_valid: a redirect sets fetch_pc <= target and goes to DROP; otherwise stay in WAIT.
  - HOLD: redirect or id_flush discards the held word (fetch_pc <= target, or fetch_pc + 4), go to ISSUE. Else if if_id_write: load IF/ID from the hold register, fetch_pc += 4, go to ISSUE. Else stay.
  - DROP: imem_valid is discarded, go to ISSUE. A further redirect updates fetch_pc and stays in DROP.
- IF/ID register priority, highest first:
  1. id_flush: bubble (valid = 0, inst = NOP_INST, pc unchanged).
  2. !if_id_write: hold.
  3. New instruction available: load it.
  4. Otherwise: bubble.
- Simultaneous id_flush and redirect: the redirect governs fetch_pc, the flush governs IF/ID; both apply.
- fetch_pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC goes to 0).
- Fetch-to-decode latency: 1 + memory latency cycles. With a 1-cycle memory, one instruction every 2 cycles.

Test Plan:
- Reset release, 1-cycle memory returning addr ^ 32'hA5A5_0000 -> requests at 0, 4, 8; if_id_pc = 0, 4, 8 with valid = 1; if_id_inst matches; bubbles in between.
- if_id_write = 0 for 3 cycles while the word from addr 4 returns -> FSM in HOLD, no new imem_req; IF/ID keeps pc 0; on release, if_id_pc = 4 and next request at 8.
- In WAIT for addr 8 (3-cycle memory), pc_src = 01, pfc = 32'h40 -> DROP; returned word is discarded; next request at 32'h40; if_id_valid stays 0 until the word from 0x40 arrives.
- pc_src = 10 with pc_write = 0 -> ignored; same with pc_write = 1 -> next request at 32'h100.
- id_flush = 1 in the same cycle imem_valid returns addr 12 -> IF/ID = NOP_INST with valid = 0; next request at 16.
- fetch_pc = 32'hFFFF_FFFC completes a fetch -> next request at 32'h0. Assert rst mid-WAIT -> outputs reset immediately; first request after release at RESET_PC.
